// File: rtl/wino_pkg.sv
// Shared constants, FSM states and tile payload for the Winograd output accumulator.
package wino_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned MEM_AW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } accum_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } tile_t;

endpackage

// File: rtl/sat_lane_add.sv
// One signed lane: a + b computed in 33 bits, clamped to the 32-bit signed range.
module sat_lane_add
  import wino_pkg::*;
(
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_sum_c,
  output logic              o_sat_c
);

  logic [LANE_W:0] w_wide;

  assign w_wide  = {i_a[LANE_W-1], i_a} + {i_b[LANE_W-1], i_b};
  // Overflow shows up as disagreement between the two top bits of the wide sum.
  assign o_sat_c = w_wide[LANE_W] ^ w_wide[LANE_W-1];

  always_comb begin
    o_sum_c = w_wide[LANE_W-1:0];
    if (o_sat_c) begin
      o_sum_c = w_wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/output_accum_writeback.sv
// Read-modify-write accumulator in front of the output memory, with
// same-address forwarding and a memory clear sequencer.
module output_accum_writeback
  import wino_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              clear_start,
  output logic              clear_done,
  output logic [MEM_AW-1:0] mem_rd_addr,
  output logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [MEM_AW-1:0] mem_wr_addr,
  output logic              mem_wr_valid,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [15:0]       tiles_done,
  output logic              sat_flag,
  output logic              busy
);

  accum_state_t      r_state;
  logic              r_in_ready;
  logic              r_clear_done;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [15:0]       r_tiles_done;
  logic              r_sat_flag;

  tile_t             r_s1;
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_last;
  logic              r_h_valid;
  logic [ADDR_W-1:0] r_h_addr;
  logic [DATA_W-1:0] r_h_data;

  logic              w_accept;
  logic              w_clear_go;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_sum;
  logic [LANES-1:0]  w_lane_sat;
  logic              w_any_sat;

  assign w_accept   = in_valid & r_in_ready;
  assign w_clear_go = (r_state == IDLE) & clear_start;
  assign w_any_sat  = r_s1_valid & (|w_lane_sat);

  // Read is issued in the accept cycle so data lands while the tile sits in S1.
  assign mem_rd_valid = w_accept;
  assign mem_rd_addr  = w_accept ? {1'b0, in_addr} : '0;

  assign mem_wr_valid = r_s2_valid | (r_state == CLEAR);
  assign mem_wr_addr  = (r_state == CLEAR) ? {1'b0, r_clr_cnt} : {1'b0, r_s2_addr};
  assign mem_wr_data  = r_s2_data;

  assign in_ready   = r_in_ready;
  assign clear_done = r_clear_done;
  assign tiles_done = r_tiles_done;
  assign sat_flag   = r_sat_flag;
  assign busy       = r_s1_valid | r_s2_valid | (r_state != IDLE);

  // Memory reads lag writes by a cycle, so recent in-flight sums win over mem_rd_data.
  always_comb begin
    w_old = mem_rd_data;
    if (r_s1.first) begin
      w_old = '0;
    end else if (r_s2_valid && (r_s2_addr == r_s1.addr)) begin
      w_old = r_s2_data;
    end else if (r_h_valid && (r_h_addr == r_s1.addr)) begin
      w_old = r_h_data;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_lane_add u_lane (
      .i_a     (w_old[g*LANE_W +: LANE_W]),
      .i_b     (r_s1.data[g*LANE_W +: LANE_W]),
      .o_sum_c (w_sum[g*LANE_W +: LANE_W]),
      .o_sat_c (w_lane_sat[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_data  <= '0;
      r_s2_last  <= 1'b0;
      r_h_valid  <= 1'b0;
      r_h_addr   <= '0;
      r_h_data   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1       <= w_accept ? tile_t'{addr: in_addr, data: in_data, first: in_first, last: in_last}
                             : '0;
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_valid ? r_s1.addr : '0;
      r_s2_data  <= r_s1_valid ? w_sum : '0;
      r_s2_last  <= r_s1_valid & r_s1.last;
      r_h_valid  <= r_s2_valid & ~w_clear_go;
      r_h_addr   <= r_s2_addr;
      r_h_data   <= r_s2_data;
    end
  end

  // Control FSM plus the counters and flags it owns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_clear_done <= 1'b0;
      r_clr_cnt    <= '0;
      r_tiles_done <= '0;
      r_sat_flag   <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      if (r_s2_valid && r_s2_last) begin
        r_tiles_done <= r_tiles_done + 16'd1;
      end
      if (w_clear_go) begin
        r_sat_flag <= 1'b0;
      end else if (w_any_sat) begin
        r_sat_flag <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (clear_start) begin
            r_in_ready <= 1'b0;
            r_state    <= (w_accept || r_s1_valid || r_s2_valid) ? DRAIN : CLEAR;
          end
        end
        DRAIN: begin
          r_in_ready <= 1'b0;
          if (!r_s1_valid && !r_s2_valid) begin
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
            r_clr_cnt    <= '0;
            r_clear_done <= 1'b1;
            r_in_ready   <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_accum_writeback.sv
// Directed bench for output_accum_writeback with a write-port scoreboard and a memory model.
module tb_output_accum_writeback;

  typedef struct packed {
    logic [7:0]   addr;
    logic [511:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_first, in_last, clear_start, clear_done;
  logic [6:0]   in_addr;
  logic [511:0] in_data;
  logic [7:0]   mem_rd_addr, mem_wr_addr;
  logic         mem_rd_valid, mem_wr_valid;
  logic [511:0] mem_rd_data, mem_wr_data;
  logic [15:0]  tiles_done;
  logic         sat_flag, busy;

  logic [511:0] mem [128];
  logic [511:0] exp_mem [128];
  logic         bk_we;
  logic [6:0]   bk_addr;
  logic [511:0] bk_data;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  output_accum_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_first     (in_first),
    .in_last      (in_last),
    .clear_start  (clear_start),
    .clear_done   (clear_done),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_data  (mem_wr_data),
    .tiles_done   (tiles_done),
    .sat_flag     (sat_flag),
    .busy         (busy)
  );

  // Memory model: load-before-store, read data one cycle after the request.
  always @(posedge clk) begin
    if (mem_rd_valid) mem_rd_data <= mem[mem_rd_addr[6:0]];
    if (mem_wr_valid) mem[mem_wr_addr[6:0]] <= mem_wr_data;
    if (bk_we) mem[bk_addr] <= bk_data;
  end

  always @(negedge clk) begin
    if (reset && mem_wr_valid) begin
      wr_t e;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected: observed write addr=%0d, expected no write", mem_wr_addr);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        assert (mem_wr_addr === e.addr && mem_wr_data === e.data) else begin
          n_fail++;
          $error("FAIL wr_beat: observed addr=%0d data=%h expected addr=%0d data=%h",
                 mem_wr_addr, mem_wr_data[63:0], e.addr, e.data[63:0]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_ref(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return 32'(s);
  endfunction

  task automatic preload(input int addr, input logic [31:0] val);
    bk_we   = 1'b1;
    bk_addr = 7'(addr);
    bk_data = {16{val}};
    exp_mem[addr] = {16{val}};
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  task automatic send(input int addr, input logic [31:0] val, input logic first, input logic last);
    logic [511:0] old, res;
    old = first ? '0 : exp_mem[addr];
    for (int l = 0; l < 16; l++) res[l*32 +: 32] = sat_ref(old[l*32 +: 32], val);
    exp_mem[addr] = res;
    sb.push_back('{addr: 8'(addr), data: res});
    in_valid = 1'b1;
    in_addr  = 7'(addr);
    in_data  = {16{val}};
    in_first = first;
    in_last  = last;
    #1;
    check("rd_issue", {55'd0, mem_rd_valid, mem_rd_addr}, {55'd0, 1'b1, 8'(addr)});
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 128; i++) begin
      sb.push_back('{addr: 8'(i), data: '0});
      exp_mem[i] = '0;
    end
  endtask

  initial begin
    int pulses;
    bit found;
    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    in_first = 1'b0; in_last = 1'b0; clear_start = 1'b0;
    bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    for (int i = 0; i < 128; i++) exp_mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_outputs", {mem_wr_valid, mem_rd_valid, clear_done, sat_flag, busy, tiles_done}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // first-pass tile: written at accept+2, no tile count
    send(5, 32'd7, 1'b1, 1'b0);
    check("lat_s1_no_write", 64'(mem_wr_valid), 64'd0);
    @(negedge clk);
    check("lat_s2_write", {55'd0, mem_wr_valid, mem_wr_addr}, {55'd0, 1'b1, 8'd5});
    idle(3);
    check("tiles_after_first", 64'(tiles_done), 64'd0);
    check("idle_wr_zero", {mem_wr_valid, mem_wr_addr, mem_wr_data[31:0]}, 64'd0);

    // accumulate onto stored value
    preload(9, 32'd100);
    send(9, 32'd3, 1'b0, 1'b1);
    idle(4);
    check("tiles_after_last", 64'(tiles_done), 64'd1);

    // back-to-back same address: S2 forward
    send(4, 32'd1, 1'b1, 1'b0);
    send(4, 32'd2, 1'b0, 1'b0);
    send(4, 32'd4, 1'b0, 1'b0);
    idle(4);

    // one-cycle gap: history forward beats the stale memory read
    preload(6, 32'd1000);
    send(6, 32'd10, 1'b1, 1'b0);
    idle(1);
    send(6, 32'd5, 1'b0, 1'b1);
    idle(4);
    check("tiles_after_fwd", 64'(tiles_done), 64'd2);

    // saturation both directions
    check("sat_before", 64'(sat_flag), 64'd0);
    preload(20, 32'h7FFF_FFF0);
    send(20, 32'h20, 1'b0, 1'b0);
    idle(4);
    check("sat_pos", 64'(sat_flag), 64'd1);
    preload(21, 32'h8000_0005);
    send(21, 32'hFFFF_FFF0, 1'b0, 1'b0);
    idle(4);
    check("sat_neg_sticky", 64'(sat_flag), 64'd1);

    // clear with two tiles in flight
    send(30, 32'd1, 1'b1, 1'b0);
    send(31, 32'd2, 1'b1, 1'b1);
    clear_start = 1'b1;
    push_clear();
    @(negedge clk);
    clear_start = 1'b0;
    check("drain_in_ready", 64'(in_ready), 64'd0);
    check("drain_busy", 64'(busy), 64'd1);
    pulses = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      if (clear_done) pulses++;
    end
    check("clear_done_pulses", 64'(pulses), 64'd1);
    check("clear_in_ready", 64'(in_ready), 64'd1);
    check("clear_sat", 64'(sat_flag), 64'd0);
    check("clear_tiles", 64'(tiles_done), 64'd3);
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_sb_empty", 64'(sb.size()), 64'd0);

    // reset in the middle of a clear
    clear_start = 1'b1;
    push_clear();
    @(negedge clk);
    clear_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (mem_wr_valid && mem_wr_addr == 8'd40) found = 1'b1;
    end
    check("reach_addr40", 64'(found), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ctrl", {in_ready, mem_wr_valid, mem_rd_valid, clear_done, sat_flag, busy}, 64'd0);
    check("rst_mid_wr", {mem_wr_addr, mem_wr_data[31:0]}, 64'd0);
    check("rst_mid_tiles", 64'(tiles_done), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_idle", {busy, mem_wr_valid}, 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
